// File: rtl/sdram_read_if.sv
// Request/response and SDRAM-pin bundle for the burst-read engine.
// The slave side is the engine; the master side is the requester, arbiter and DQ source.
interface sdram_read_if;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [9:0]  rd_bst_len;
  logic        init_end;
  logic [15:0] rd_sdram_data;
  logic        rd_ack;
  logic        rd_end;
  logic [3:0]  rd_sdram_cmd;
  logic [1:0]  rd_sdram_bank;
  logic [12:0] rd_sdram_addr;
  logic [15:0] rd_data;

  modport slave (
    input  rd_en, rd_addr, rd_bst_len, init_end, rd_sdram_data,
    output rd_ack, rd_end, rd_sdram_cmd, rd_sdram_bank, rd_sdram_addr, rd_data
  );

  modport master (
    output rd_en, rd_addr, rd_bst_len, init_end, rd_sdram_data,
    input  rd_ack, rd_end, rd_sdram_cmd, rd_sdram_bank, rd_sdram_addr, rd_data
  );
endinterface

// File: rtl/sdram_read.sv
// SDRAM burst-read engine: ACT, READ, burst-stop, PRE, with a per-word ack strobe.
// Command/bank/address outputs are registered from the next state, so they line up with the state.
module sdram_read #(
  parameter int T_RCD = 2,
  parameter int T_CL  = 3,
  parameter int T_RP  = 2
) (
  input  logic       rd_clk,
  input  logic       rd_rst_n,
  sdram_read_if.slave bus
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  typedef enum logic [3:0] {
    IDLE, ACT, TRCD, RD, DATA, BST, CL, PRE, TRP, END
  } state_t;

  state_t      state, state_n;
  logic [15:0] wait_cnt;
  logic [15:0] dat_cnt;
  logic        dat_run;
  logic [15:0] dat_last;

  logic [1:0]  bank_q;
  logic [12:0] row_q;
  logic [8:0]  col_q;
  logic [9:0]  len_q;

  logic [3:0]  cmd_q, cmd_n;
  logic [1:0]  bank_o, bank_n;
  logic [12:0] addr_o, addr_n;
  logic        ack_q;
  logic        end_q;
  logic [15:0] data_q;

  logic        start;
  assign start = (state == IDLE) && bus.init_end && bus.rd_en;

  // Next state: every timed state leaves when the shared wait counter hits its last cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = ACT;
      ACT:  state_n = (T_RCD == 1) ? RD : TRCD;
      TRCD: if (wait_cnt + 16'd2 == 16'(T_RCD)) state_n = RD;
      RD:   state_n = (len_q == 10'd1) ? BST : DATA;
      DATA: if (wait_cnt + 16'd2 == {6'd0, len_q}) state_n = BST;
      BST:  state_n = CL;
      CL:   if (wait_cnt + 16'd1 == 16'(T_CL)) state_n = PRE;
      PRE:  state_n = (T_RP == 1) ? END : TRP;
      TRP:  if (wait_cnt + 16'd2 == 16'(T_RP)) state_n = END;
      END:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ACT is only entered from IDLE, so its row comes straight from the request inputs.
  always_comb begin
    cmd_n  = CMD_NOP;
    bank_n = 2'b11;
    addr_n = 13'h1FFF;
    unique case (state_n)
      ACT: begin
        cmd_n  = CMD_ACT;
        bank_n = bus.rd_addr[23:22];
        addr_n = bus.rd_addr[21:9];
      end
      RD: begin
        cmd_n  = CMD_RD;
        bank_n = bank_q;
        addr_n = {4'b0000, col_q};
      end
      BST: begin
        cmd_n  = CMD_BST;
        bank_n = bank_q;
      end
      PRE: begin
        cmd_n  = CMD_PRE;
        bank_n = bank_q;
        addr_n = 13'h0000;
      end
      default: ;
    endcase
  end

  assign dat_last = 16'(T_CL) + {6'd0, len_q} - 16'd1;

  always_ff @(posedge rd_clk) begin
    if (start) begin
      bank_q <= bus.rd_addr[23:22];
      row_q  <= bus.rd_addr[21:9];
      col_q  <= bus.rd_addr[8:0];
      len_q  <= (bus.rd_bst_len == 10'd0) ? 10'd1 : bus.rd_bst_len;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state    <= IDLE;
      wait_cnt <= 16'd0;
      dat_cnt  <= 16'd0;
      dat_run  <= 1'b0;
      cmd_q    <= CMD_NOP;
      bank_o   <= 2'b11;
      addr_o   <= 13'h1FFF;
      ack_q    <= 1'b0;
      end_q    <= 1'b0;
      data_q   <= 16'h0000;
    end else begin
      state    <= state_n;
      wait_cnt <= (state_n != state || state == IDLE) ? 16'd0 : wait_cnt + 16'd1;
      cmd_q    <= cmd_n;
      bank_o   <= bank_n;
      addr_o   <= addr_n;
      end_q    <= (state_n == END);
      data_q   <= bus.rd_sdram_data;
      // Data counter runs from the READ cycle; words sit on DQ from T_CL onward and show up one edge later.
      ack_q    <= dat_run && (dat_cnt >= 16'(T_CL)) && (dat_cnt <= dat_last);
      if (state_n == RD && state != RD) begin
        dat_run <= 1'b1;
        dat_cnt <= 16'd0;
      end else if (dat_run) begin
        if (dat_cnt == dat_last) begin
          dat_run <= 1'b0;
          dat_cnt <= 16'd0;
        end else begin
          dat_cnt <= dat_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.rd_sdram_cmd  = cmd_q;
  assign bus.rd_sdram_bank = bank_o;
  assign bus.rd_sdram_addr = addr_o;
  assign bus.rd_ack        = ack_q;
  assign bus.rd_end        = end_q;
  assign bus.rd_data       = data_q;

endmodule

// File: tb/tb_sdram_read.sv
// Bench for sdram_read: per-cycle command/ack/data schedule derived from the timing rules,
// with random DQ traffic recorded so captured words can be checked.
module tb_sdram_read;

  localparam int T_RCD = 2;
  localparam int T_CL  = 3;
  localparam int T_RP  = 2;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RDC = 4'b0101;
  localparam logic [3:0] BST = 4'b0110;
  localparam logic [3:0] PRE = 4'b0010;

  logic rd_clk;
  logic rd_rst_n;
  sdram_read_if bus ();

  sdram_read #(.T_RCD(T_RCD), .T_CL(T_CL), .T_RP(T_RP)) dut (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .bus      (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dq_base = 0;
  bit incr_mode = 0;
  logic [15:0] hist [1024];

  initial begin
    rd_clk = 0;
    forever #5 rd_clk = ~rd_clk;
  end

  // DQ source: random words, or an incrementing pattern starting at word 0 of a burst.
  initial begin
    forever begin
      @(posedge rd_clk);
      cyc++;
      #1;
      if (incr_mode) bus.rd_sdram_data = 16'(cyc - dq_base);
      else           bus.rd_sdram_data = 16'($urandom);
      hist[cyc % 1024] = bus.rd_sdram_data;
    end
  end

  task automatic check_idle_outputs(input string tag);
    checks++; if (bus.rd_sdram_cmd !== NOP) begin failures++; $display("FAIL %s cmd got=%b exp=%b", tag, bus.rd_sdram_cmd, NOP); end
    checks++; if (bus.rd_sdram_bank !== 2'b11) begin failures++; $display("FAIL %s bank got=%b exp=11", tag, bus.rd_sdram_bank); end
    checks++; if (bus.rd_sdram_addr !== 13'h1FFF) begin failures++; $display("FAIL %s addr got=%h exp=1fff", tag, bus.rd_sdram_addr); end
    checks++; if (bus.rd_ack !== 1'b0) begin failures++; $display("FAIL %s ack got=%b exp=0", tag, bus.rd_ack); end
    checks++; if (bus.rd_end !== 1'b0) begin failures++; $display("FAIL %s end got=%b exp=0", tag, bus.rd_end); end
  endtask

  // One full read; cycle 0 is the cycle in which rd_en is presented while the engine is idle.
  task automatic run_read(input logic [23:0] a, input logic [9:0] len, input bit keep,
                          input bit drop, input bit incr, input string tag);
    int L, k, bst, pre, endc, c0, last;
    logic [3:0] ec;
    logic exp_ack, exp_end;
    logic [15:0] exp_d;
    L    = (len == 10'd0) ? 1 : int'(len);
    k    = 1 + T_RCD;
    bst  = k + L;
    pre  = bst + T_CL + 1;
    endc = pre + T_RP;
    last = keep ? endc : endc + 1;
    @(posedge rd_clk); #1;
    bus.init_end = 1'b1;
    bus.rd_en = 1'b1;
    bus.rd_addr = a;
    bus.rd_bst_len = len;
    c0 = cyc;
    if (incr) begin dq_base = cyc + k + T_CL; incr_mode = 1'b1; end
    for (int r = 1; r <= last; r++) begin
      @(posedge rd_clk); #1;
      if (!keep && r == endc) bus.rd_en = 1'b0;
      if (drop && r == k + 1) bus.rd_en = 1'b0;
      bus.rd_addr = 24'($urandom);
      bus.rd_bst_len = 10'($urandom);
      @(negedge rd_clk);
      checks++; if (cyc - c0 !== r) begin failures++; $display("FAIL %s cycle_align got=%0d exp=%0d", tag, cyc - c0, r); end
      ec = (r == 1) ? ACT : (r == k) ? RDC : (r == bst) ? BST : (r == pre) ? PRE : NOP;
      checks++;
      if (bus.rd_sdram_cmd !== ec) begin
        failures++; $display("FAIL %s cmd@%0d got=%b exp=%b", tag, r, bus.rd_sdram_cmd, ec);
      end
      if (r == 1 || r == k || r == pre) begin
        checks++;
        if (bus.rd_sdram_bank !== a[23:22]) begin
          failures++; $display("FAIL %s bank@%0d got=%b exp=%b", tag, r, bus.rd_sdram_bank, a[23:22]);
        end
      end
      if (r == 1) begin
        checks++;
        if (bus.rd_sdram_addr !== a[21:9]) begin failures++; $display("FAIL %s row got=%h exp=%h", tag, bus.rd_sdram_addr, a[21:9]); end
      end
      if (r == k) begin
        checks++;
        if (bus.rd_sdram_addr !== {4'b0000, a[8:0]}) begin failures++; $display("FAIL %s col got=%h exp=%h", tag, bus.rd_sdram_addr, {4'b0000, a[8:0]}); end
      end
      if (r == pre) begin
        checks++;
        if (bus.rd_sdram_addr[10] !== 1'b0) begin failures++; $display("FAIL %s pre_a10 got=%b exp=0", tag, bus.rd_sdram_addr[10]); end
      end
      exp_ack = (r >= k + T_CL + 1) && (r <= k + T_CL + L);
      checks++;
      if (bus.rd_ack !== exp_ack) begin failures++; $display("FAIL %s ack@%0d got=%b exp=%b", tag, r, bus.rd_ack, exp_ack); end
      if (exp_ack) begin
        exp_d = incr ? 16'(r - (k + T_CL + 1)) : hist[(cyc - 1) % 1024];
        checks++;
        if (bus.rd_data !== exp_d) begin failures++; $display("FAIL %s data@%0d got=%h exp=%h", tag, r, bus.rd_data, exp_d); end
      end
      exp_end = (r == endc);
      checks++;
      if (bus.rd_end !== exp_end) begin failures++; $display("FAIL %s end@%0d got=%b exp=%b", tag, r, bus.rd_end, exp_end); end
    end
    incr_mode = 1'b0;
  endtask

  task automatic test_reset;
    rd_rst_n = 1'b0;
    bus.init_end = 1'b0;
    bus.rd_en = 1'b1;
    bus.rd_addr = 24'h000000;
    bus.rd_bst_len = 10'd4;
    bus.rd_sdram_data = 16'h0000;
    repeat (3) @(posedge rd_clk);
    @(negedge rd_clk);
    check_idle_outputs("reset");
    checks++; if (bus.rd_data !== 16'h0000) begin failures++; $display("FAIL reset data got=%h exp=0000", bus.rd_data); end
    @(posedge rd_clk); #1;
    rd_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge rd_clk);
      checks++;
      if (bus.rd_sdram_cmd !== NOP) begin failures++; $display("FAIL no_init cmd got=%b exp=%b", bus.rd_sdram_cmd, NOP); end
    end
    run_read(24'h123456, 10'd3, 1'b0, 1'b0, 1'b0, "init_rise");
  endtask

  task automatic test_incr_data;
    run_read(24'h000000, 10'd10, 1'b0, 1'b0, 1'b1, "incr10");
  endtask

  task automatic test_len1;
    run_read(24'hC01205, 10'd1, 1'b0, 1'b0, 1'b0, "len1");
  endtask

  task automatic test_len0;
    run_read(24'hC01205, 10'd0, 1'b0, 1'b0, 1'b0, "len0");
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      run_read(24'($urandom), 10'($urandom_range(1, 40)), 1'b0, 1'b0, 1'b0, "random");
    run_read(24'($urandom), 10'd512, 1'b0, 1'b0, 1'b0, "len512");
  endtask

  task automatic test_back_to_back;
    run_read(24'($urandom), 10'($urandom_range(1, 12)), 1'b1, 1'b0, 1'b0, "b2b_first");
    run_read(24'($urandom), 10'($urandom_range(1, 12)), 1'b1, 1'b0, 1'b0, "b2b_second");
    run_read(24'($urandom), 10'($urandom_range(1, 12)), 1'b0, 1'b0, 1'b0, "b2b_third");
  endtask

  task automatic test_drop_en;
    run_read(24'($urandom), 10'd16, 1'b0, 1'b1, 1'b0, "drop_en");
  endtask

  task automatic test_reset_mid;
    @(posedge rd_clk); #1;
    bus.init_end = 1'b1;
    bus.rd_en = 1'b1;
    bus.rd_addr = 24'h5A5A5A;
    bus.rd_bst_len = 10'd20;
    repeat (1 + T_RCD + 3) @(posedge rd_clk);
    #2;
    rd_rst_n = 1'b0;
    bus.rd_en = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    checks++; if (bus.rd_data !== 16'h0000) begin failures++; $display("FAIL mid_reset data got=%h exp=0000", bus.rd_data); end
    repeat (2) @(posedge rd_clk);
    #1 rd_rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge rd_clk);
      checks++;
      if (bus.rd_sdram_cmd !== NOP || bus.rd_ack !== 1'b0 || bus.rd_end !== 1'b0) begin
        failures++;
        $display("FAIL post_reset cmd=%b ack=%b end=%b exp cmd=%b ack=0 end=0", bus.rd_sdram_cmd, bus.rd_ack, bus.rd_end, NOP);
      end
    end
    run_read(24'($urandom), 10'd7, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_incr_data;
    test_len1;
    test_len0;
    test_random;
    test_back_to_back;
    test_drop_en;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
